pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter DW, default 32, data lane width in bits.
REQ-002 The module SHALL have parameter NLANE, default 2, number of data lanes (operands).
REQ-003 The module SHALL have parameter CW, default 17, control-bundle width (regdst, regwrite, memtoreg, alusrc, aluop, AW, sel packed).
REQ-004 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The module SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 The module SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 The module SHALL have port in_ready, output, 1, stage can accept a beat.
REQ-008 The module SHALL have port in_data, input, NLANE*DW, packed operand lanes, lane 0 in LSBs.
REQ-009 The module SHALL have port in_ctrl, input, CW, control bundle.
REQ-010 The module SHALL have port flush, input, 1, discard all held beats.
REQ-011 The module SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 The module SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 The module SHALL have port out_data, output, NLANE*DW, registered operand lanes.
REQ-014 The module SHALL have port out_ctrl, output, CW, registered control bundle.
REQ-015 The module SHALL have port stall_cnt, output, 16, stall-cycle counter (see Configuration).
REQ-016 The module SHALL have port flush_cnt, output, 16, flush-event counter (see Configuration).

Function
REQ-017 A beat SHALL transfer in on in_valid&&in_ready and out on out_valid&&out_ready, both sampled at the rising edge of clk.
REQ-018 Storage SHALL be two entries, a main register driving the outputs and a skid register, with FSM states EMPTY (0 held), ONE (main valid), FULL (main and skid valid).
REQ-019 in_ready SHALL be a registered output equal to (state!=FULL) and SHALL NOT combinationally depend on out_ready.
REQ-020 EMPTY: on input transfer, load main and go to ONE; otherwise stay.
REQ-021 ONE: on input transfer with output transfer, reload main and stay ONE; on input only, load skid and go FULL; on output only, go EMPTY.
REQ-022 FULL: on output transfer, move skid to main and go ONE; otherwise hold.
REQ-023 Latency SHALL be one cycle from input transfer to out_valid when EMPTY; beat order SHALL be preserved, with no loss and no duplication.
REQ-024 When out_valid=0, out_ctrl SHALL read all-zero, so a bubble never asserts regwrite or memtoreg; out_data SHALL hold its last value.
REQ-025 flush SHALL take priority over all transfers: the next state SHALL be EMPTY with out_valid=0, and any beat offered that cycle SHALL be discarded.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL remain stable.

Reset
REQ-027 With rst_n=0 at a clock edge, the state SHALL become EMPTY and out_valid, in_ready, out_data, out_ctrl, stall_cnt and flush_cnt SHALL become 0.
REQ-028 in_ready SHALL rise to 1 on the first edge after rst_n returns to 1.
REQ-029 Reset mid-operation SHALL drop all held beats, with no out_valid in the cycle following the reset edge.

Configuration
REQ-030 With macro PIPE_SKID_STATS_EN defined, stall_cnt SHALL increment on each cycle with out_valid&&!out_ready, flush_cnt SHALL increment on each cycle with flush=1, and both SHALL saturate at 16'hFFFF.
REQ-031 Without PIPE_SKID_STATS_EN, no counter logic SHALL be built and stall_cnt and flush_cnt SHALL be tied to 0.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the FSM state typedef (EMPTY/ONE/FULL), the control-bundle field offsets and widths, and the counter width constant 16.
REQ-033 The statistics counters SHALL be one sub-module, pipe_sat_cnt, a parametrised saturating counter instantiated twice.

Verification
REQ-034 The bench SHALL apply reset, then in_valid=1 with lane0=32'h1, lane1=32'h2 and out_ready=1, and SHALL check out_valid=1 with those lanes one cycle later.
REQ-035 The bench SHALL hold out_ready=0 and push beats A=5, B=6, C=7, and SHALL check that in_ready falls after B and C is refused; on out_ready=1 it SHALL check the output order A,B.
REQ-036 The bench SHALL fill to FULL and assert flush with in_valid=1 (beat 9), and SHALL check out_valid=0 the next cycle and that beat 9 never appears.
REQ-037 The bench SHALL stream 100 beats with random out_ready at 50%, and SHALL check in-order, lossless delivery and that out_ctrl=0 whenever out_valid=0.
REQ-038 The bench SHALL drive rst_n=0 while FULL, and SHALL check that all outputs are 0 and that in_ready=1 one cycle after release.
REQ-039 With PIPE_SKID_STATS_EN defined, the bench SHALL stall 3 cycles and flush twice, and SHALL check stall_cnt=3 and flush_cnt=2; without the macro it SHALL check both read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM states, control-bundle field layout and counter width for the skid stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Control bundle packed LSB first: regdst, regwrite, memtoreg, alusrc, aluop, aw, sel
  localparam int REGDST_OFF   = 0;
  localparam int REGDST_W     = 1;
  localparam int REGWRITE_OFF = 1;
  localparam int REGWRITE_W   = 1;
  localparam int MEMTOREG_OFF = 2;
  localparam int MEMTOREG_W   = 1;
  localparam int ALUSRC_OFF   = 3;
  localparam int ALUSRC_W     = 1;
  localparam int ALUOP_OFF    = 4;
  localparam int ALUOP_W      = 4;
  localparam int AW_OFF       = 8;
  localparam int AW_W         = 5;
  localparam int SEL_OFF      = 13;
  localparam int SEL_W        = 4;
  localparam int CTRL_W       = SEL_OFF + SEL_W;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter used for the stage statistics
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register; PIPE_SKID_STATS_EN builds stall/flush counters
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NLANE = 2,
  parameter int CW    = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NLANE*DW-1:0] in_data,
  input  logic [CW-1:0]       in_ctrl,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NLANE*DW-1:0] out_data,
  output logic [CW-1:0]       out_ctrl,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int BW = NLANE * DW;

  state_t        state_q;
  state_t        state_d;
  logic          in_ready_q;
  logic [BW-1:0] main_data;
  logic [BW-1:0] skid_data;
  logic [CW-1:0] main_ctrl;
  logic [CW-1:0] skid_ctrl;
  logic          in_xfer;
  logic          out_xfer;
  logic          load_main;
  logic          load_skid;
  logic          move_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = main_data;
  // Bubbles must never carry regwrite/memtoreg downstream.
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            move_skid = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so it never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_SKID_STATS_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - randomized bench for pipe_skid_reg against a queue reference model
module tb_pipe_skid_reg;

  localparam int DW    = 32;
  localparam int NLANE = 2;
  localparam int CW    = 17;
  localparam int BW    = DW * NLANE;
  localparam int EW    = BW + CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DW(DW), .NLANE(NLANE), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: held beats as a FIFO of at most two, readiness decided one edge ahead.
  logic [EW-1:0] mq[$];
  logic          m_rdy  = 1'b0;
  logic          m_in_x = 1'b0;
  logic [BW-1:0] m_last = '0;
  int            m_stall = 0;
  int            m_flush = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rdy   = 1'b0;
      m_last  = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush && m_flush < 65535) m_flush++;
      if (flush) begin
        mq.delete();
        m_rdy = 1'b1;
      end else begin
        m_in_x = in_valid && m_rdy;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (m_in_x) mq.push_back({in_ctrl, in_data});
        m_rdy = (mq.size() < 2);
      end
      if (mq.size() > 0) m_last = mq[0][BW-1:0];
    end
  end

  task automatic compare_model();
    logic [CW-1:0] exp_ctrl;
    exp_ctrl = '0;
    if (mq.size() > 0) exp_ctrl = mq[0][EW-1:BW];
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, m_rdy);
    check("out_data", out_data, m_last);
    check("out_ctrl", out_ctrl, exp_ctrl);
`ifdef PIPE_SKID_STATS_EN
    check("stall_cnt", stall_cnt, m_stall[15:0]);
    check("flush_cnt", flush_cnt, m_flush[15:0]);
`else
    check("stall_cnt", stall_cnt, 0);
    check("flush_cnt", flush_cnt, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_beat(input logic [31:0] l0, input logic [31:0] l1, input logic [CW-1:0] c);
    in_data = {l1, l0};
    in_ctrl = c;
  endtask

  logic [EW-1:0] sq[$];
  int            sent;
  int            recv;
  int            cyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", in_ready, 1);

    // First beat, one-cycle latency
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(32'h1, 32'h2, 17'h0_1234);
    tick();
    check("first_valid", out_valid, 1);
    check("first_lanes", out_data, {32'h2, 32'h1});
    in_valid = 1'b0;
    tick();

    // Backpressure: A and B held, C refused
    out_ready = 1'b0; in_valid = 1'b1;
    set_beat(32'h5, 32'h50, 17'h0_0002);
    tick();
    set_beat(32'h6, 32'h60, 17'h0_0006);
    tick();
    check("ready_fall_after_b", in_ready, 0);
    set_beat(32'h7, 32'h70, 17'h0_0007);
    tick();
    in_valid = 1'b0;
    check("order_a", out_data[31:0], 32'h5);
    out_ready = 1'b1;
    tick();
    check("order_b", out_data[31:0], 32'h6);
    tick();
    check("c_refused", out_valid, 0);

    // Flush while FULL with a beat offered
    out_ready = 1'b0; in_valid = 1'b1;
    set_beat(32'h11, 32'h0, 17'h0_0011);
    tick();
    set_beat(32'h12, 32'h0, 17'h0_0012);
    tick();
    flush = 1'b1;
    set_beat(32'h9, 32'h9, 17'h1_FFFF);
    tick();
    check("flush_empty", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_beat9", out_valid, 0);
    end

    // Random stream with scoreboard
    sent = 0; recv = 0; cyc = 0;
    while (recv < 100 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 100) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom(), $urandom()};
        in_ctrl  = CW'($urandom());
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && m_rdy) begin
        sq.push_back({in_ctrl, in_data});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sq.size() > 0) begin
          check("stream_beat", {out_ctrl, out_data}, sq[0]);
          void'(sq.pop_front());
        end else begin
          check("stream_extra", recv, sent);
        end
        recv++;
      end
      if (!out_valid) check("bubble_ctrl", out_ctrl, 0);
      tick();
      cyc++;
    end
    check("stream_count", recv, 100);
    in_valid = 1'b0;

    // Reset while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    set_beat(32'h21, 32'h22, 17'h0_0F0F);
    tick();
    set_beat(32'h23, 32'h24, 17'h0_0A0A);
    tick();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    check("rst_full_valid", out_valid, 0);
    check("rst_full_ready", in_ready, 0);
    check("rst_full_data", out_data, 0);
    check("rst_full_ctrl", out_ctrl, 0);
    check("rst_full_stall", stall_cnt, 0);
    check("rst_full_flush", flush_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", in_ready, 1);
    check("rst_release_valid", out_valid, 0);

    // Statistics: three stall cycles, two flushes
    in_valid = 1'b1;
    set_beat(32'h31, 32'h32, 17'h0_0003);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    tick();
`ifdef PIPE_SKID_STATS_EN
    check("stats_stall", stall_cnt, 3);
    check("stats_flush", flush_cnt, 2);
`else
    check("stats_stall_off", stall_cnt, 0);
    check("stats_flush_off", flush_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
